// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Datapath and instruction-memory signals of the fetch stage, as seen from either side.
interface instr_fetch_unit_if;

    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jr;
    logic [31:0] seOut;
    logic [31:0] reg_Da;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instructions;
    logic [31:0] pc_id;
    logic        misalign;

    // Fetch unit side
    modport slave (
        input  stall, branch, zero, jump, jr, seOut, reg_Da, imem_rdata,
        output imem_addr, Instructions, pc_id, misalign
    );

    // Datapath / memory side
    modport master (
        output stall, branch, zero, jump, jr, seOut, reg_Da, imem_rdata,
        input  imem_addr, Instructions, pc_id, misalign
    );

endinterface

// File: rtl/Register.sv
// Width-parameterised enabled register with synchronous active-high reset.
module Register #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_next_pc.sv
// Next-PC priority select: jr > jump > taken branch > sequential.
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_id,
    input  logic [31:0] pc_ex,
    input  logic [25:0] instr_index,
    input  logic        jr,
    input  logic        jump,
    input  logic        taken,
    input  logic [31:0] se_out,
    input  logic [31:0] reg_da,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] seq_target;
    logic [31:0] jr_target;
    logic [31:0] pc_id_step;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    always_comb begin
        seq_target    = pc + PC_STEP;
        jr_target     = reg_da & ~32'd3;
        pc_id_step    = pc_id + PC_STEP;
        // Region bits come from the PC after the jump, not the jump itself
        jump_target   = (pc_id_step & 32'hF000_0000) | {4'b0000, instr_index, 2'b00};
        branch_target = pc_ex + PC_STEP + (se_out << 2);

        redirect = jr | jump | taken;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = seq_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, squashes the wrong-path word after a redirect
// and replays its last output while the datapath stalls.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.slave     bus
);

    localparam int HIST_DEPTH = 3;

    logic        advance;
    logic        taken;
    logic        redirect;
    logic [31:0] next_pc_d;
    logic [31:0] pc_hist_d [HIST_DEPTH];
    logic [31:0] pc_hist_q [HIST_DEPTH];
    logic [31:0] pc_q;
    logic [31:0] pc_id_q;
    logic [31:0] pc_ex_q;
    logic [31:0] hold_d;
    logic [31:0] hold_q;
    logic        hold_v_d;
    logic        hold_v_q;
    logic [31:0] live_word;
    logic [31:0] instructions;
    ifu_state_t  state_d;
    ifu_state_t  state_q;
    logic        misalign_d;
    logic        misalign_q;

    assign advance = ~bus.stall;
    assign taken   = bus.branch & bus.zero;
    assign pc_q    = pc_hist_q[0];
    assign pc_id_q = pc_hist_q[1];
    assign pc_ex_q = pc_hist_q[2];

    ifu_next_pc u_next_pc (
        .pc          (pc_q),
        .pc_id       (pc_id_q),
        .pc_ex       (pc_ex_q),
        .instr_index (instructions[25:0]),
        .jr          (bus.jr),
        .jump        (bus.jump),
        .taken       (taken),
        .se_out      (bus.seOut),
        .reg_da      (bus.reg_Da),
        .next_pc     (next_pc_d),
        .redirect    (redirect)
    );

    // PC history shifts fetch -> ID -> EX as one unit, frozen under stall
    always_comb begin
        pc_hist_d[0] = next_pc_d;
        pc_hist_d[1] = pc_hist_q[0];
        pc_hist_d[2] = pc_hist_q[1];
    end

    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_pc_hist
        Register #(
            .WIDTH     (32),
            .RESET_VAL ((gi == 0) ? RESET_PC : 32'd0)
        ) u_pc_reg (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (pc_hist_d[gi]),
            .q   (pc_hist_q[gi])
        );
    end

    always_comb begin
        hold_d   = instructions;
        hold_v_d = bus.stall;
    end

    Register #(.WIDTH(32), .RESET_VAL(NOP_WORD)) u_hold_word (
        .clk (clk),
        .rst (rst),
        .en  (bus.stall),
        .d   (hold_d),
        .q   (hold_q)
    );

    Register #(.WIDTH(1), .RESET_VAL(1'b0)) u_hold_valid (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (hold_v_d),
        .q   (hold_v_q)
    );

    always_comb begin
        state_d    = state_q;
        misalign_d = misalign_q;
        if (advance) begin
            unique case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = redirect ? SQUASH : RUN;
                SQUASH:  state_d = redirect ? SQUASH : RUN;
                default: state_d = BOOT;
            endcase
            if (bus.jr) begin
                misalign_d = |bus.reg_Da[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    // Only RUN delivers memory data; BOOT has no valid read and SQUASH carries the fall-through word
    always_comb begin
        live_word    = (state_q == RUN) ? bus.imem_rdata : NOP_WORD;
        instructions = hold_v_q ? hold_q : live_word;
    end

    assign bus.imem_addr    = pc_q;
    assign bus.Instructions = instructions;
    assign bus.pc_id        = pc_id_q;
    assign bus.misalign     = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle expectations go into a queue, a monitor checks them.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcid;
        logic        mis;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   cyc_no;
    exp_t exp_q[$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: low 26 bits echo the address, top bits inverted so no word equals NOP
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {~a[31:26], a[25:0]};
    endfunction

    always @(posedge clk) bus.imem_rdata <= imem_word(bus.imem_addr);

    task automatic check(input int c, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cyc%0d %s: got %h expected %h", c, name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("cyc%0d addr=%h instr=%h pc_id=%h misalign=%b",
                         e.cyc, bus.imem_addr, bus.Instructions, bus.pc_id, bus.misalign);
                check(e.cyc, "imem_addr", bus.imem_addr, e.addr);
                check(e.cyc, "Instructions", bus.Instructions, e.instr);
                check(e.cyc, "pc_id", bus.pc_id, e.pcid);
                check(e.cyc, "misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
            end
        end
    end

    // Drive inputs for the current cycle, queue the outputs expected in this cycle, advance one clock
    task automatic cyc(input logic r, input logic st, input logic br, input logic zr,
                       input logic jp, input logic j_r, input logic [31:0] se, input logic [31:0] da,
                       input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pcid, input logic e_mis);
        exp_t e;
        rst        = r;
        bus.stall  = st;
        bus.branch = br;
        bus.zero   = zr;
        bus.jump   = jp;
        bus.jr     = j_r;
        bus.seOut  = se;
        bus.reg_Da = da;
        e.cyc   = cyc_no;
        e.addr  = e_addr;
        e.instr = e_instr;
        e.pcid  = e_pcid;
        e.mis   = e_mis;
        exp_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        n_cmp  = 0;
        n_fail = 0;
        cyc_no = 0;
        rst = 1'b1;
        bus.stall = 0; bus.branch = 0; bus.zero = 0; bus.jump = 0; bus.jr = 0;
        bus.seOut = 0; bus.reg_Da = 0;
        repeat (2) @(posedge clk);
        #1;
        //   rst st br zr jp jr seOut       reg_Da        addr          instr                        pc_id         mis
        // Sequential fetch from reset
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0000, NOP,                          32'h0000_0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0004, imem_word(32'h0000_0000),     32'h0000_0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0008, imem_word(32'h0000_0004),     32'h0000_0004, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_000C, imem_word(32'h0000_0008),     32'h0000_0008, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0010, imem_word(32'h0000_000C),     32'h0000_000C, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0014, imem_word(32'h0000_0010),     32'h0000_0010, 0);
        // Taken branch: pc_ex = 0x10, seOut = 3 -> 0x20, one squashed word
        cyc(0, 0, 1, 1, 0, 0, 32'd3, 32'd0,         32'h0000_0018, imem_word(32'h0000_0014),     32'h0000_0014, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0020, NOP,                          32'h0000_0018, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0024, imem_word(32'h0000_0020),     32'h0000_0020, 0);
        // Not-taken branch: no redirect, no squash
        cyc(0, 0, 1, 0, 0, 0, 32'd3, 32'd0,         32'h0000_0028, imem_word(32'h0000_0024),     32'h0000_0024, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_002C, imem_word(32'h0000_0028),     32'h0000_0028, 0);
        // Misaligned jr, then jr+jump+branch together while squashing: jr wins
        cyc(0, 0, 0, 0, 0, 1, 32'd0, 32'h0000_0102, 32'h0000_0030, imem_word(32'h0000_002C),     32'h0000_002C, 0);
        cyc(0, 0, 1, 1, 1, 1, 32'd5, 32'h0000_0200, 32'h0000_0100, NOP,                          32'h0000_0030, 1);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0200, NOP,                          32'h0000_0100, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0204, imem_word(32'h0000_0200),     32'h0000_0200, 0);
        // Three-cycle stall: outputs frozen, nothing lost on release
        cyc(0, 1, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0208, imem_word(32'h0000_0204),     32'h0000_0204, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0208, imem_word(32'h0000_0204),     32'h0000_0204, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0208, imem_word(32'h0000_0204),     32'h0000_0204, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0208, imem_word(32'h0000_0204),     32'h0000_0204, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_020C, imem_word(32'h0000_0208),     32'h0000_0208, 0);
        // Jump on word(0x20C): index 0x20C -> target 0x830; then jr 0x400 during SQUASH
        cyc(0, 0, 0, 0, 1, 0, 32'd0, 32'd0,         32'h0000_0210, imem_word(32'h0000_020C),     32'h0000_020C, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'd0, 32'h0000_0400, 32'h0000_0830, NOP,                          32'h0000_0210, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0400, NOP,                          32'h0000_0830, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0404, imem_word(32'h0000_0400),     32'h0000_0400, 0);
        // Reset asserted during a stall
        cyc(0, 1, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0408, imem_word(32'h0000_0404),     32'h0000_0404, 0);
        cyc(1, 1, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0408, imem_word(32'h0000_0404),     32'h0000_0404, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0000, NOP,                          32'h0000_0000, 0);
        // jr to the top word, then sequential wrap to 0
        cyc(0, 0, 0, 0, 0, 1, 32'd0, 32'hFFFF_FFFC, 32'h0000_0004, imem_word(32'h0000_0000),     32'h0000_0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'hFFFF_FFFC, NOP,                          32'h0000_0004, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0000, imem_word(32'hFFFF_FFFC),     32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'd0, 32'd0,         32'h0000_0004, imem_word(32'h0000_0000),     32'h0000_0000, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
